// File: rtl/dcpu_sram_bridge.sv
// ---------------------------------------------------------------------------
// dcpu_sram_bridge
//
// Bus slave between the dcpu core memory port and an external 8-bit
// asynchronous SRAM. Each 16-bit strobed request is split into one byte
// access per active lane (low lane first). Accesses to two lanes are separated
// by one recovery cycle with all SRAM strobes released. A completed request
// is answered with a one-cycle acknowledge carrying the assembled read data.
// If the core drops i_cyc mid-request, the byte access in flight still
// completes. Any remaining lanes are skipped and no acknowledge is returned.
//
// Every output is a register loaded from next-state values. No combinational
// path runs from any input to any output.
//
// Parameters
//   AW    SRAM byte-address width
//   WAIT  extra cycles per byte access (only with the macro below)
//
// Optional feature macro: SRAM_BRIDGE_WAITSTATES_EN
//   defined   : a wait counter stretches every byte access to WAIT+1 cycles
//   undefined : every byte access lasts exactly one cycle, WAIT is ignored
//
// Ports
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_cyc, i_stb       bus cycle and byte-lane strobes ([0] low, [1] high)
//   i_we, i_addr       write enable, byte address (bits [AW-1:1] used)
//   i_dat              write data
//   o_ack, o_dat       one-cycle acknowledge and read data
//   o_sram_addr        SRAM byte address
//   o_sram_dat         SRAM write data, o_sram_dat_oe enables the pin driver
//   i_sram_dat         SRAM read data
//   o_sram_ce_n/oe_n/we_n  active-low SRAM controls
// ---------------------------------------------------------------------------
module dcpu_sram_bridge #(
  parameter int AW   = 19,
  parameter int WAIT = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cyc,
  input  logic [1:0]    i_stb,
  input  logic          i_we,
  input  logic [31:0]   i_addr,
  input  logic [15:0]   i_dat,
  output logic          o_ack,
  output logic [15:0]   o_dat,
  output logic [AW-1:0] o_sram_addr,
  output logic [7:0]    o_sram_dat,
  input  logic [7:0]    i_sram_dat,
  output logic          o_sram_dat_oe,
  output logic          o_sram_ce_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_we_n
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t        state_q, state_d;

  // Latched request
  logic [AW-2:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [15:0]   wdat_q, wdat_d;
  logic [1:0]    stb_q, stb_d;
  logic          lane_q, lane_d;
  logic [15:0]   rdat_q, rdat_d;
  logic          abort_q, abort_d;

  // Registered outputs
  logic          ack_q, ack_d;
  logic [15:0]   datOut_q, datOut_d;
  logic [AW-1:0] sramAddr_q, sramAddr_d;
  logic [7:0]    sramDat_q, sramDat_d;
  logic          datOe_q, datOe_d;
  logic          ceN_q, ceN_d;
  logic          oeN_q, oeN_d;
  logic          weN_q, weN_d;

  // High when the current ACCESS cycle is the last one of the byte access
  logic          accessLast;

  // Address bit 0 and the bits above the SRAM size carry no meaning here
  logic          unusedAddr;
  assign unusedAddr = ^{i_addr[31:AW], i_addr[0]};

`ifdef SRAM_BRIDGE_WAITSTATES_EN
  localparam int WW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

  logic [WW-1:0] wait_q, wait_d;

  assign accessLast = (wait_q == '0);

  // The wait counter is reloaded whenever a byte access begins. It then counts
  // down once per ACCESS cycle, and the access ends in the cycle where it
  // reads zero.
  always_comb begin
    wait_d = wait_q;
    if (state_d == ACCESS && state_q != ACCESS) begin
      wait_d = WW'(WAIT);
    end else if (state_q == ACCESS && !accessLast) begin
      wait_d = wait_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic [31:0] unusedWait;
  assign unusedWait = 32'(WAIT);
  assign accessLast = 1'b1;
`endif

  // Request sequencing. IDLE captures a request and picks the first strobed
  // lane. ACCESS holds the byte access and, on reads, captures the SRAM byte
  // in its final cycle. RECOVER separates the two lanes of a halfword. A
  // dropped i_cyc is remembered so the access in flight can finish cleanly
  // before falling back to IDLE without an acknowledge.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    stb_d   = stb_q;
    lane_d  = lane_q;
    rdat_d  = rdat_q;
    abort_d = abort_q;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (i_cyc && i_stb != 2'b00) begin
          addr_d  = i_addr[AW-1:1];
          we_d    = i_we;
          wdat_d  = i_dat;
          stb_d   = i_stb;
          lane_d  = ~i_stb[0];
          rdat_d  = '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (!i_cyc) begin
          abort_d = 1'b1;
        end
        if (accessLast) begin
          if (!we_q) begin
            if (lane_q) begin
              rdat_d[15:8] = i_sram_dat;
            end else begin
              rdat_d[7:0] = i_sram_dat;
            end
          end
          if (abort_d) begin
            state_d = IDLE;
          end else if (!lane_q && stb_q[1]) begin
            state_d = RECOVER;
          end else begin
            state_d = ACK;
          end
        end
      end

      RECOVER: begin
        if (!i_cyc) begin
          state_d = IDLE;
        end else begin
          lane_d  = 1'b1;
          state_d = ACCESS;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The output values for the coming cycle are derived from the next state.
  // Address and write data hold their last value outside ACCESS, so nothing
  // moves on the SRAM pins around a write strobe.
  always_comb begin
    ack_d      = 1'b0;
    datOut_d   = '0;
    ceN_d      = 1'b1;
    oeN_d      = 1'b1;
    weN_d      = 1'b1;
    datOe_d    = 1'b0;
    sramAddr_d = sramAddr_q;
    sramDat_d  = sramDat_q;

    case (state_d)
      ACCESS: begin
        ceN_d      = 1'b0;
        sramAddr_d = {addr_d, lane_d};
        if (we_d) begin
          weN_d     = 1'b0;
          datOe_d   = 1'b1;
          sramDat_d = lane_d ? wdat_d[15:8] : wdat_d[7:0];
        end else begin
          oeN_d = 1'b0;
        end
      end
      ACK: begin
        ack_d    = 1'b1;
        datOut_d = rdat_d;
      end
      default: begin
      end
    endcase
  end

  // State, request and output registers. Reset wins over everything and
  // immediately releases all SRAM strobes, including a write in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdat_q     <= '0;
      stb_q      <= '0;
      lane_q     <= 1'b0;
      rdat_q     <= '0;
      abort_q    <= 1'b0;
      ack_q      <= 1'b0;
      datOut_q   <= '0;
      sramAddr_q <= '0;
      sramDat_q  <= '0;
      datOe_q    <= 1'b0;
      ceN_q      <= 1'b1;
      oeN_q      <= 1'b1;
      weN_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdat_q     <= wdat_d;
      stb_q      <= stb_d;
      lane_q     <= lane_d;
      rdat_q     <= rdat_d;
      abort_q    <= abort_d;
      ack_q      <= ack_d;
      datOut_q   <= datOut_d;
      sramAddr_q <= sramAddr_d;
      sramDat_q  <= sramDat_d;
      datOe_q    <= datOe_d;
      ceN_q      <= ceN_d;
      oeN_q      <= oeN_d;
      weN_q      <= weN_d;
    end
  end

  assign o_ack         = ack_q;
  assign o_dat         = datOut_q;
  assign o_sram_addr   = sramAddr_q;
  assign o_sram_dat    = sramDat_q;
  assign o_sram_dat_oe = datOe_q;
  assign o_sram_ce_n   = ceN_q;
  assign o_sram_oe_n   = oeN_q;
  assign o_sram_we_n   = weN_q;

endmodule

// File: doc/dcpu_sram_bridge.md
# dcpu_sram_bridge

Bus slave that sits directly downstream of the dcpu core's memory port and services its 16-bit strobed requests from an external 8-bit asynchronous SRAM. Each request is split into one or two byte accesses, one per active byte lane. The bridge returns a single-cycle acknowledge with the assembled 16-bit read data. It is the only memory target the core sees for both instruction fetch and load/store traffic.

## Interface
- AW, 19: SRAM byte-address width (512 KiB).
- WAIT, 2: extra cycles per byte access (used only with SRAM_BRIDGE_WAITSTATES_EN).

- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_cyc  in  1  bus cycle active (core o_cyc).
- i_stb  in  2  byte-lane strobes; [0] = low byte, [1] = high byte (core o_stb).
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  32  byte address; bits [AW-1:1] used; bit 0 ignored.
- i_dat  in  16  write data.
- o_ack  out  1  one-cycle transfer complete.
- o_dat  out  16  read data, valid while o_ack = 1.
- o_sram_addr  out  AW  SRAM byte address.
- o_sram_dat  out  8  SRAM write data.
- i_sram_dat  in  8  SRAM read data.
- o_sram_dat_oe  out  1  data-pin drive enable (top level builds the tristate).
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n  out  1 each  active-low SRAM controls.

One clock; reset is synchronous and active-high (ports i_clk, i_reset).

## Operation
- States: IDLE, ACCESS, RECOVER, ACK.
- IDLE:
  - If i_cyc = 1 and i_stb != 0: latch i_addr, i_we, i_dat and i_stb.
  - Select the first lane: lane 0 if stb[0] is set, else lane 1.
  - Clear the read-data register, load the wait counter, go to ACCESS.
- ACCESS:
  - SRAM address = {addr[AW-1:1], lane}. Little-endian: the even byte is the low byte.
  - ce_n = 0 throughout.
  - Read: oe_n = 0, dat_oe = 0.
  - Write: we_n = 0, dat_oe = 1, o_sram_dat = lane ? dat[15:8] : dat[7:0].
  - Access ends when the wait counter reaches 0.
  - On a read, the last ACCESS cycle samples i_sram_dat into byte `lane` of the read register.
- After ACCESS:
  - If the other lane is also strobed and not yet done: go to RECOVER.
  - Otherwise: go to ACK.
- RECOVER (1 cycle):
  - ce_n, oe_n, we_n = 1; dat_oe = 0.
  - Address held at the previous lane.
  - Then ACCESS on lane 1.
- ACK (1 cycle):
  - o_ack = 1; o_dat = read register.
  - Unstrobed byte reads 0; reads as 0 on writes.
  - Then IDLE. A request still present in IDLE is treated as a new transfer.
- Abort: if i_cyc falls during ACCESS or RECOVER:
  - The byte access in progress completes normally; a write is never truncated.
  - Remaining lanes are skipped.
  - Return to IDLE without o_ack.
- Reset mid-operation: next edge forces IDLE and all outputs to reset values; an SRAM write in progress is cut.

## Timing
- Reset values:
  - o_ack = 0, o_dat = 0.
  - o_sram_addr = 0, o_sram_dat = 0, o_sram_dat_oe = 0.
  - ce_n, oe_n, we_n = 1.
- Request sampled in IDLE at edge 0. Let A = ACCESS length in cycles.
  - Single byte: ACK in cycle A+1.
  - Halfword: ACK in cycle 2A+2.
- A = 1 without the macro. A = WAIT+1 with the macro.
- All outputs are registered, with no combinational path from i_* to o_*.
- Minimum spacing between acks: halfword 2A+3 cycles, byte A+2 cycles (one IDLE cycle included).
- we_n is high for at least one cycle between byte writes. The address never changes while we_n = 0.

## Configuration
- SRAM_BRIDGE_WAITSTATES_EN:
  - Defined: wait counter present; each ACCESS lasts WAIT+1 cycles (WAIT = 0 legal).
  - Undefined: counter removed; ACCESS is always 1 cycle and WAIT is ignored.

## Test plan
- Reset: assert i_reset 2 cycles with i_cyc = 1 -> all outputs at reset values, no SRAM strobe, o_ack = 0.
- Halfword read, macro off:
  - Stimulus: addr 0x0000_1234, stb = 11; SRAM holds 0x1234 = 0xCD, 0x1235 = 0xAB.
  - Response: o_ack in cycle 4, o_dat = 0xABCD.
- Byte write, high lane:
  - Stimulus: addr 0x10, stb = 10, i_dat = 0x5A00.
  - Response: a single we_n pulse at 0x11 with data 0x5A; ack in cycle 2; 0x10 untouched.
- Wait states:
  - Stimulus: macro on, WAIT = 3, halfword write 0xBEEF to 0x20.
  - Response: we_n low 4 cycles at 0x20 (0xEF), 1 recover cycle, 4 cycles at 0x21 (0xBE); ack in cycle 10.
- Abort: drop i_cyc during RECOVER of a halfword write -> only 0x20 written, no o_ack, IDLE next cycle.
- Back-to-back: hold i_cyc/stb across an ack -> second transfer starts after one IDLE cycle; two distinct acks, no merged strobes.
